// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a bank of 7-segment
// digits sharing one active-low segment bus.
//
// Purpose : holds one hex nibble + decimal point + visible flag per digit and
//           cycles through the digits. Each slot is a blanking gap (all anodes
//           off) followed by a dwell period driving that digit.
// Latency : every output is registered. The first digit is driven
//           BLANK_CYCLES+1 edges after enable rises from idle.
// Flow    : no backpressure. Host writes are accepted on every cycle.
//           A write never disturbs the digit that is being shown.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   enable                  1 = scanning, 0 = dark and parked at slot 0
//   wr_en/wr_idx/wr_data/   single-cycle register-file write port;
//   wr_dp/wr_vis            indices >= NUM_DIGITS are ignored
//   seg_out                 active-low segments {a,b,c,d,e,f,g,dp}
//   an_out                  active-low anodes, one-hot-low while driving
//   scan_idx                current slot index
//   frame_tick              one-cycle pulse when the scan wraps to slot 0

module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int IDX_W        = 3,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  wr_vis,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic [IDX_W-1:0]      scan_idx,
  output logic                  frame_tick
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  // Active-high segment pattern {a,b,c,d,e,f,g,dp=0} for a hex nibble.
  function automatic logic [7:0] hex_pattern(input logic [3:0] nib);
    logic [7:0] p;
    case (nib)
      4'h0: p = 8'hFC;
      4'h1: p = 8'h60;
      4'h2: p = 8'hDA;
      4'h3: p = 8'hF2;
      4'h4: p = 8'h66;
      4'h5: p = 8'hB6;
      4'h6: p = 8'hBE;
      4'h7: p = 8'hE0;
      4'h8: p = 8'hFE;
      4'h9: p = 8'hF6;
      4'hA: p = 8'hEE;
      4'hB: p = 8'h3E;
      4'hC: p = 8'h9C;
      4'hD: p = 8'h7A;
      4'hE: p = 8'h9E;
      default: p = 8'h8E;
    endcase
    return p;
  endfunction

  // Sequencer state.
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic [IDX_W-1:0]        idx_q,   idx_d;

  // Registered outputs.
  logic [7:0]              seg_q,   seg_d;
  logic [NUM_DIGITS-1:0]   an_q,    an_d;
  logic                    tick_q,  tick_d;

  // Digit register file.
  logic [NUM_DIGITS-1:0][3:0] data_q;
  logic [NUM_DIGITS-1:0]      dp_q;
  logic [NUM_DIGITS-1:0]      vis_q;

  // Read port for the current slot.
  logic [3:0]              rd_data;
  logic                    rd_dp;
  logic                    rd_vis;

  // Compare-based mux instead of direct indexing, so an IDX_W wider than
  // needed for NUM_DIGITS simply selects nothing.
  always_comb begin
    rd_data = 4'h0;
    rd_dp   = 1'b0;
    rd_vis  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rd_data = data_q[i];
        rd_dp   = dp_q[i];
        rd_vis  = vis_q[i];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seg_d   = 8'hFF;
    an_d    = '1;
    tick_d  = 1'b0;

    if (!enable) begin
      // Disable wins from any state. The display goes dark and parks at slot 0.
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_LOAD;
          idx_d   = '0;
        end

        ST_BLANK: begin
          if (cnt_q == '0) begin
            state_d = ST_DRIVE;
            cnt_d   = DWELL_LOAD;
            // The digit is captured here and held for the whole dwell.
            // A write on this same edge lands in the file after the capture,
            // so it only shows up on the next frame.
            seg_d   = ~(hex_pattern(rd_data) | {7'b0, rd_dp});
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (idx_q == IDX_W'(i)) begin
                an_d[i] = ~rd_vis;
              end
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_DRIVE: begin
          if (cnt_q == '0) begin
            // Dwell done: go dark and advance to the next slot.
            state_d = ST_BLANK;
            cnt_d   = BLANK_LOAD;
            if (idx_q == LAST_IDX) begin
              idx_d  = '0;
              tick_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            seg_d = seg_q;
            an_d  = an_q;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  // Register file. Out-of-range indices match no entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dp_q   <= '0;
      vis_q  <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          data_q[i] <= wr_data;
          dp_q[i]   <= wr_dp;
          vis_q[i]  <= wr_vis;
        end
      end
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign scan_idx   = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of 7-segment digits that share one active-low segment bus.
- Holds one hex nibble plus decimal-point flag per digit, written by the host through a single-cycle write port.
- Cycles through the digits with a programmable dwell time. All anodes are off for a blanking gap between digits, which prevents ghosting.
- Sits between the host logic (switch or encoder results) and the board's segment and anode pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned. Range 2..8.
- IDX_W, 3: width of a digit index; must satisfy 2**IDX_W >= NUM_DIGITS.
- DWELL_CYCLES, 50000: clock cycles each digit is driven. Must be >= 1.
- BLANK_CYCLES, 500: clock cycles with all anodes off before each digit. Must be >= 1.
- CNT_W, 16: width of the dwell/blank counter; must hold max(DWELL_CYCLES, BLANK_CYCLES)-1.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: 1 = scanning runs; 0 = display dark.
- wr_en, input, 1: write strobe for the digit register file.
- wr_idx, input, IDX_W: digit index to write. Values >= NUM_DIGITS are ignored.
- wr_data, input, 4: hex nibble 0x0..0xF.
- wr_dp, input, 1: decimal-point on for that digit.
- wr_vis, input, 1: digit visible. 0 = anode held off during its slot.
- seg_out, output, 8: active-low segments. Bit7..1 = a,b,c,d,e,f,g; bit0 = dp.
- an_out, output, NUM_DIGITS: active-low digit enables, one-hot-low while driving.
- scan_idx, output, IDX_W: index of the current slot.
- frame_tick, output, 1: one-cycle pulse when the scan wraps from NUM_DIGITS-1 to 0.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - state = IDLE, counter = 0, scan_idx = 0.
  - seg_out = 8'hFF, an_out = all ones, frame_tick = 0.
  - All register-file entries = {vis=0, dp=0, data=0}.
  - Reset mid-scan blanks the outputs immediately.
- Register file:
  - A write with wr_en=1 updates entry wr_idx on the clock edge.
  - A write never alters the digit currently displayed. The change is seen at that digit's next DRIVE entry.
  - A write on the same edge as the DRIVE entry is not visible until the following frame. This means the latch samples pre-write contents.
- FSM states: IDLE, BLANK, DRIVE. All outputs are registered.
  - IDLE:
    - Outputs dark.
    - enable=1 -> BLANK with scan_idx = 0 and counter = BLANK_CYCLES-1.
  - BLANK:
    - Outputs dark. Counter decrements.
    - At counter 0 -> DRIVE with counter = DWELL_CYCLES-1.
    - On this entry edge, seg_out and an_out load from entry scan_idx.
  - DRIVE:
    - seg_out = ~pattern(data) with bit0 = ~dp.
    - an_out[scan_idx] = ~vis; all other anode bits = 1.
    - Counter decrements. At counter 0 -> BLANK with scan_idx+1 and outputs dark.
    - scan_idx wraps from NUM_DIGITS-1 to 0. frame_tick = 1 on that same edge only.
  - enable=0 in any state -> IDLE on the next edge: outputs dark, scan_idx = 0, counter = 0.
- Timing:
  - Slot period = BLANK_CYCLES + DWELL_CYCLES.
  - Frame period = NUM_DIGITS * slot period.
  - First DRIVE begins BLANK_CYCLES+1 edges after enable rises in IDLE.
- Invisible digit (vis=0): the slot still consumes full time so brightness stays uniform. Its anode stays high and seg_out still shows the pattern.
- Active-high segment patterns (a..g,dp); output is their inverse:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0
  - 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E

Test Plan:
- Bench configuration for all scenarios: NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2, so slot = 6 cycles and frame = 24 cycles.
- Reset and idle: hold rst_n=0, then release with enable=0 for 20 cycles -> seg_out=FF, an_out=1111, scan_idx=0, frame_tick never 1.
- Basic scan:
  - Stimulus: write idx0..3 = 1, 2, 3, A, all vis=1, dp=0, then raise enable.
  - Required: 2 dark cycles after IDLE exit, then an_out=1110 and seg_out=9F for 4 cycles.
  - Then 2 dark cycles, then an_out=1101 and seg_out=25.
  - The same pattern continues through digits 2 and 3.
  - frame_tick pulses once every 24 cycles.
- Decimal point and invisible digit:
  - Stimulus: idx2 = {data=8, dp=1}; idx1 with vis=0.
  - Required: the slot 2 drive shows seg_out=00.
  - Slot 1 keeps an_out=1111 for the full 6 cycles, and the frame timing is unchanged.
- Write during own DRIVE:
  - Stimulus: while slot 0 is driving "1", write idx0=7.
  - Required: seg_out stays 9F until the slot ends; the next frame's slot 0 shows 1F.
  - A write to idx 5 (out of range) changes nothing.
- Disable and reset mid-operation:
  - Deassert enable during slot 2 DRIVE -> one edge later the outputs are dark and scan_idx=0.
  - Re-enable -> the scan restarts at slot 0 after 2 blank cycles.
  - Assert rst_n=0 asynchronously mid-DRIVE -> seg_out=FF and an_out=1111 without waiting for a clock edge, and all entries are cleared.
